// File: rtl/frog_game_ctrl.sv
// Round/move controller for the frog grid.
// Turns synchronized key levels into single-cycle legal move pulses, tracks the
// frog position, handles goal-row wins and car collisions, and keeps score/lives.
//
// state | meaning
// ------+-----------------------------------------------------------
// PLAY  | normal play; key edges become moves, collision costs a life
// WIN   | frog reached goal row; next edge pulses roundWin, score+1
// HIT   | frog was hit; next edge pulses roundWin, frog back to start
// OVER  | game ended (win or out of lives); frozen until reset
module frog_game_ctrl #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int START_COL = 3,
    parameter int WIN_SCORE = 7,
    parameter int LIVES     = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           keyL,
    input  logic                           keyR,
    input  logic                           keyF,
    input  logic                           keyB,
    input  logic                           collision,
    output logic                           L,
    output logic                           R,
    output logic                           F,
    output logic                           B,
    output logic                           roundWin,
    output logic [$clog2(ROWS)-1:0]        frogRow,
    output logic [$clog2(COLS)-1:0]        frogCol,
    output logic [$clog2(WIN_SCORE+1)-1:0] score,
    output logic [$clog2(LIVES+1)-1:0]     lives,
    output logic                           gameOver,
    output logic                           gameWon
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(WIN_SCORE + 1);
    localparam int LW = $clog2(LIVES + 1);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_WIN  = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t state, state_nx;

    logic keyL_d, keyR_d, keyF_d, keyB_d;
    logic [3:0] press;

    logic          L_nx, R_nx, F_nx, B_nx, roundWin_nx;
    logic [RW-1:0] row_nx;
    logic [CW-1:0] col_nx;
    logic [SW-1:0] score_nx;
    logic [LW-1:0] lives_nx;
    logic          gameOver_nx, gameWon_nx;

    logic legal_l, legal_r, legal_f, legal_b;

    // Rising edges of the key levels; bit order is {B, F, R, L}.
    assign press = {keyB & ~keyB_d, keyF & ~keyF_d, keyR & ~keyR_d, keyL & ~keyL_d};

    assign legal_l = (frogCol != '0);
    assign legal_r = (frogCol != CW'(COLS - 1));
    assign legal_b = (frogRow != '0);
    assign legal_f = (frogRow != RW'(ROWS - 1));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nx    = state;
        L_nx        = 1'b0;
        R_nx        = 1'b0;
        F_nx        = 1'b0;
        B_nx        = 1'b0;
        roundWin_nx = 1'b0;
        row_nx      = frogRow;
        col_nx      = frogCol;
        score_nx    = score;
        lives_nx    = lives;
        gameOver_nx = gameOver;
        gameWon_nx  = gameWon;

        case (state)
            S_PLAY: begin
                if (collision) begin
                    // A hit wins over any simultaneous move.
                    lives_nx = lives - LW'(1);
                    state_nx = S_HIT;
                end else if ($onehot(press)) begin
                    if (press[0] && legal_l) begin
                        L_nx   = 1'b1;
                        col_nx = frogCol - CW'(1);
                    end
                    if (press[1] && legal_r) begin
                        R_nx   = 1'b1;
                        col_nx = frogCol + CW'(1);
                    end
                    if (press[2] && legal_f) begin
                        F_nx   = 1'b1;
                        row_nx = frogRow + RW'(1);
                        if (frogRow == RW'(ROWS - 2)) begin
                            state_nx = S_WIN;
                        end
                    end
                    if (press[3] && legal_b) begin
                        B_nx   = 1'b1;
                        row_nx = frogRow - RW'(1);
                    end
                end
            end
            S_WIN: begin
                roundWin_nx = 1'b1;
                row_nx      = '0;
                col_nx      = CW'(START_COL);
                score_nx    = score + SW'(1);
                if (score_nx == SW'(WIN_SCORE)) begin
                    state_nx    = S_OVER;
                    gameOver_nx = 1'b1;
                    gameWon_nx  = 1'b1;
                end else begin
                    state_nx = S_PLAY;
                end
            end
            S_HIT: begin
                roundWin_nx = 1'b1;
                row_nx      = '0;
                col_nx      = CW'(START_COL);
                if (lives == '0) begin
                    state_nx    = S_OVER;
                    gameOver_nx = 1'b1;
                    gameWon_nx  = 1'b0;
                end else begin
                    state_nx = S_PLAY;
                end
            end
            default: begin
                state_nx = S_OVER;
            end
        endcase
    end

    // State, key history and output registers. Key history follows the keys in
    // every state (including reset) so a held key never produces a late pulse.
    always_ff @(posedge clk) begin
        keyL_d <= keyL;
        keyR_d <= keyR;
        keyF_d <= keyF;
        keyB_d <= keyB;
        if (reset) begin
            state    <= S_PLAY;
            L        <= 1'b0;
            R        <= 1'b0;
            F        <= 1'b0;
            B        <= 1'b0;
            roundWin <= 1'b0;
            frogRow  <= '0;
            frogCol  <= CW'(START_COL);
            score    <= '0;
            lives    <= LW'(LIVES);
            gameOver <= 1'b0;
            gameWon  <= 1'b0;
        end else begin
            state    <= state_nx;
            L        <= L_nx;
            R        <= R_nx;
            F        <= F_nx;
            B        <= B_nx;
            roundWin <= roundWin_nx;
            frogRow  <= row_nx;
            frogCol  <= col_nx;
            score    <= score_nx;
            lives    <= lives_nx;
            gameOver <= gameOver_nx;
            gameWon  <= gameWon_nx;
        end
    end

endmodule
